serial_mem_loader: RTL and testbench
====================================

Name: serial_mem_loader

Overview:
- Initiator on the word-wide `mem_*` request/response interface, i.e. the other end of the SRAM controller: it sits where the CPU normally drives memory.
- Driven by a byte command stream from `rs232in` (`received_data` / `attention`); replies through `rs232out` (`transmit_data` / `we` / `busy`).
- Used for loading and inspecting PSRAM over the serial link while the CPU is held in reset; the top level muxes it onto the memory port.

Parameters:
- MEM_ID, 2'd3 — value driven on `mem_id`; read data is accepted only when `mem_readdataid` equals it; must be non-zero.
- TIMEOUT_CYCLES, 48_000_000 — parser inactivity limit in clocks; used only with the optional feature.

Ports:
- clock  in  1  — system clock; all state on posedge.
- rst  in  1  — asynchronous, active-high reset.
- rx_data  in  8  — received byte from `rs232in`.
- rx_attention  in  1  — one-cycle strobe: `rx_data` valid.
- tx_data  out  8  — byte to `rs232out`.
- tx_we  out  1  — one-cycle write strobe to `rs232out`.
- tx_busy  in  1  — `rs232out` busy.
- mem_waitrequest  in  1  — controller stall.
- mem_id  out  2  — constant MEM_ID.
- mem_address  out  30  — word address.
- mem_read  out  1  — read request.
- mem_write  out  1  — write request.
- mem_writedata  out  32  — write data.
- mem_writedatamask  out  4  — byte enables; always 4'hF.
- mem_readdata  in  32  — read data.
- mem_readdataid  in  2  — tag of `mem_readdata`; 0 means no data this cycle.
- busy  out  1  — high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: `mem_read`=0, `mem_write`=0, `tx_we`=0, `mem_address`=0, `mem_writedata`=0, `tx_data`=0, `busy`=0; FSM in IDLE; byte counter 0.
- Commands (ASCII):
  - 'W'(0x57) + 4 address bytes + 4 data bytes → write one word; reply 'K'(0x4B).
  - 'R'(0x52) + 4 address bytes → read one word; reply 4 data bytes.
  - Any other byte in IDLE → reply '?'(0x3F).
- Byte order: address and data are big-endian. `mem_address` = byte_addr[31:2]; byte_addr[1:0] are ignored.
- FSM states: IDLE, GET_ADDR, GET_DATA, MEM_REQ, MEM_WAIT_DATA, TX_SEND, TX_WAIT.
  - IDLE → GET_ADDR on 'R'/'W'.
  - GET_ADDR: collect 4 bytes (2-bit counter), shifting left by 8. Then 'W' → GET_DATA; 'R' → MEM_REQ.
  - GET_DATA: collect 4 bytes, then → MEM_REQ.
  - MEM_REQ: assert `mem_read` or `mem_write` with address/data stable. The request is accepted on the first posedge with `mem_waitrequest`=0; deassert on the following cycle.
    - Write accepted → TX_SEND with 'K'.
    - Read accepted → MEM_WAIT_DATA.
  - MEM_WAIT_DATA: capture `mem_readdata` in the cycle `mem_readdataid`==MEM_ID (may be the same cycle as acceptance+1 or later); any other id is ignored. Then → TX_SEND with 4 bytes, MSB first.
  - TX_SEND: when `tx_busy`=0, pulse `tx_we` for one cycle → TX_WAIT.
  - TX_WAIT: skip one cycle, then wait for `tx_busy`=0. More bytes pending → TX_SEND; else → IDLE.
- Bytes arriving outside IDLE/GET_ADDR/GET_DATA (mem or tx phases) are dropped silently.
- Exactly one request in flight; no pipelining. Latency from the final command byte to request assertion is 1 clock.
- `rst` mid-operation: outputs drop immediately (asynchronously). An in-flight read's data returning after reset is ignored, since the FSM is in IDLE.

Optional Feature:
- Macro: SERIAL_LOADER_TIMEOUT_EN.
- Defined: a counter restarts on each `rx_attention`. If GET_ADDR or GET_DATA sees no byte for TIMEOUT_CYCLES clocks, the FSM returns to IDLE without a memory access or reply, and the partial command is discarded.
- Undefined: no counter; the parser waits indefinitely.

Decomposition:
- Package `serial_mem_loader_pkg`:
  - command byte constants CMD_READ, CMD_WRITE, RSP_OK, RSP_ERR;
  - FSM state encoding (localparams, 3 bits);
  - WORD_BYTES=4.
- One sub-module: `loader_tx_seq`, which loads 1..4 bytes plus a count and serialises them over the `tx_data`/`tx_we`/`tx_busy` handshake (TX_SEND/TX_WAIT live there), with a done pulse back to the main FSM.

Test Plan:
- Write: bytes 57 00 00 01 00 DE AD BE EF, waitrequest=0 → one `mem_write` pulse, `mem_address`=30'h40, `mem_writedata`=32'hDEADBEEF, mask F; `tx_data`=4B.
- Read with stall: bytes 52 00 00 01 03, waitrequest high for 5 cycles, data 32'h12345678 returned with id 3 after 3 further cycles → `mem_read` held 6 cycles with address 30'h40; tx sequence 12 34 56 78.
- Foreign id: during MEM_WAIT_DATA drive id=1 with data 32'hFFFFFFFF, then id=3 with 32'h0BADF00D → reply 0B AD F0 0D.
- Unknown command: byte 41 → reply 3F, no memory activity. Byte arriving while `tx_busy` → dropped.
- Reset mid-read: assert `rst` in MEM_REQ → `mem_read`=0 immediately. Later returned data with id 3 produces no tx.
- SERIAL_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=100: send 57 00, wait 101 cycles, then 52 00 00 00 00 → treated as a new read of address 0; the stale write never occurs.

Source files
------------

// File: rtl/serial_mem_loader_pkg.sv
// Shared constants for the serial memory loader: command bytes,
// FSM state encoding and word size.
package serial_mem_loader_pkg;

    localparam int WORD_BYTES = 4;

    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h3F;

    localparam logic [2:0] ST_IDLE          = 3'd0;
    localparam logic [2:0] ST_GET_ADDR      = 3'd1;
    localparam logic [2:0] ST_GET_DATA      = 3'd2;
    localparam logic [2:0] ST_MEM_REQ       = 3'd3;
    localparam logic [2:0] ST_MEM_WAIT_DATA = 3'd4;
    localparam logic [2:0] ST_TX_SEND       = 3'd5;
    localparam logic [2:0] ST_TX_WAIT       = 3'd6;

    typedef enum logic [2:0] {
        IDLE          = ST_IDLE,
        GET_ADDR      = ST_GET_ADDR,
        GET_DATA      = ST_GET_DATA,
        MEM_REQ       = ST_MEM_REQ,
        MEM_WAIT_DATA = ST_MEM_WAIT_DATA,
        TX_SEND       = ST_TX_SEND,
        TX_WAIT       = ST_TX_WAIT
    } state_t;

endpackage

// File: rtl/serial_mem_loader_tx_seq.sv
// loader_tx_seq: serialises 1..4 reply bytes (MSB first) over the
// tx_data/tx_we/tx_busy handshake and pulses done after the last one.
module loader_tx_seq
    import serial_mem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] word,
    input  logic [2:0]  count,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_we,
    output logic        done
);

    state_t      state_q, state_n;
    logic [31:0] shreg_q, shreg_n;
    logic [2:0]  left_q, left_n;
    logic        skip_q, skip_n;
    logic [7:0]  data_n;
    logic        we_n;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= 32'h0;
            left_q  <= 3'd0;
            skip_q  <= 1'b0;
            tx_data <= 8'h00;
            tx_we   <= 1'b0;
        end else begin
            state_q <= state_n;
            shreg_q <= shreg_n;
            left_q  <= left_n;
            skip_q  <= skip_n;
            tx_data <= data_n;
            tx_we   <= we_n;
        end
    end

    // skip_q gives rs232out one cycle to raise busy after each write
    always_comb begin
        state_n = state_q;
        shreg_n = shreg_q;
        left_n  = left_q;
        skip_n  = 1'b0;
        data_n  = tx_data;
        we_n    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_n = word;
                    left_n  = count;
                    state_n = TX_SEND;
                end
            end
            TX_SEND: begin
                if (!tx_busy) begin
                    we_n    = 1'b1;
                    data_n  = shreg_q[31:24];
                    shreg_n = {shreg_q[23:0], 8'h00};
                    left_n  = left_q - 3'd1;
                    skip_n  = 1'b1;
                    state_n = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (!skip_q && !tx_busy) begin
                    if (left_q != 3'd0) begin
                        state_n = TX_SEND;
                    end else begin
                        done    = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/serial_mem_loader.sv
// Serial-command memory initiator: 'W' writes a word, 'R' reads one back.
// Define SERIAL_LOADER_TIMEOUT_EN to abandon stalled partial commands.
module serial_mem_loader
    import serial_mem_loader_pkg::*;
#(
    parameter logic [1:0]  MEM_ID         = 2'd3,
    parameter int unsigned TIMEOUT_CYCLES = 48_000_000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_attention,
    output logic [7:0]  tx_data,
    output logic        tx_we,
    input  logic        tx_busy,
    input  logic        mem_waitrequest,
    output logic [1:0]  mem_id,
    output logic [29:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_writedatamask,
    input  logic [31:0] mem_readdata,
    input  logic [1:0]  mem_readdataid,
    output logic        busy
);

    state_t      state_q, state_n;
    logic [1:0]  cnt_q, cnt_n;
    logic        is_wr_q, is_wr_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] wdata_q, wdata_n;
    logic        rd_q, rd_n;
    logic        wr_q, wr_n;
    logic        tx_start;
    logic [31:0] tx_word;
    logic [2:0]  tx_count;
    logic        tx_done;
    logic        timeout;

    assign mem_id            = MEM_ID;
    assign mem_address       = addr_q[31:2];
    assign mem_read          = rd_q;
    assign mem_write         = wr_q;
    assign mem_writedata     = wdata_q;
    assign mem_writedatamask = 4'hF;
    assign busy              = (state_q != IDLE);

`ifdef SERIAL_LOADER_TIMEOUT_EN
    logic [31:0] idle_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            idle_q <= 32'd0;
        end else if (rx_attention ||
                     !(state_q == GET_ADDR || state_q == GET_DATA)) begin
            idle_q <= 32'd0;
        end else if (!timeout) begin
            idle_q <= idle_q + 32'd1;
        end
    end

    assign timeout = (idle_q >= 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;

    assign timeout    = 1'b0;
    assign unused_tmo = ^32'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            is_wr_q <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            is_wr_q <= is_wr_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            rd_q    <= rd_n;
            wr_q    <= wr_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        is_wr_n  = is_wr_q;
        addr_n   = addr_q;
        wdata_n  = wdata_q;
        rd_n     = rd_q;
        wr_n     = wr_q;
        tx_start = 1'b0;
        tx_word  = 32'h0;
        tx_count = 3'd0;
        unique case (state_q)
            IDLE: begin
                if (rx_attention) begin
                    cnt_n = 2'd0;
                    if (rx_data == CMD_READ || rx_data == CMD_WRITE) begin
                        is_wr_n = (rx_data == CMD_WRITE);
                        state_n = GET_ADDR;
                    end else begin
                        tx_start = 1'b1;
                        tx_word  = {RSP_ERR, 24'h0};
                        tx_count = 3'd1;
                        state_n  = TX_SEND;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_attention) begin
                    addr_n = {addr_q[23:0], rx_data};
                    cnt_n  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (is_wr_q) begin
                            state_n = GET_DATA;
                        end else begin
                            rd_n    = 1'b1;
                            state_n = MEM_REQ;
                        end
                    end
                end else if (timeout) begin
                    state_n = IDLE;
                end
            end
            GET_DATA: begin
                if (rx_attention) begin
                    wdata_n = {wdata_q[23:0], rx_data};
                    cnt_n   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        wr_n    = 1'b1;
                        state_n = MEM_REQ;
                    end
                end else if (timeout) begin
                    state_n = IDLE;
                end
            end
            MEM_REQ: begin
                if (!mem_waitrequest) begin
                    rd_n = 1'b0;
                    wr_n = 1'b0;
                    if (is_wr_q) begin
                        tx_start = 1'b1;
                        tx_word  = {RSP_OK, 24'h0};
                        tx_count = 3'd1;
                        state_n  = TX_SEND;
                    end else begin
                        state_n = MEM_WAIT_DATA;
                    end
                end
            end
            MEM_WAIT_DATA: begin
                if (mem_readdataid == MEM_ID) begin
                    tx_start = 1'b1;
                    tx_word  = mem_readdata;
                    tx_count = 3'(WORD_BYTES);
                    state_n  = TX_SEND;
                end
            end
            TX_SEND: begin
                if (tx_done) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    loader_tx_seq u_tx_seq (
        .clock   (clock),
        .rst     (rst),
        .start   (tx_start),
        .word    (tx_word),
        .count   (tx_count),
        .tx_busy (tx_busy),
        .tx_data (tx_data),
        .tx_we   (tx_we),
        .done    (tx_done)
    );

endmodule

// File: tb/tb_serial_mem_loader.sv
// Bench for serial_mem_loader: serial commands against a word-memory model.
// With SERIAL_LOADER_TIMEOUT_EN defined the parser timeout is also exercised.
`timescale 1ns/1ps
module tb_serial_mem_loader;
    import serial_mem_loader_pkg::*;

    localparam logic [1:0] MID = 2'd3;

    logic        clock = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_attention;
    logic [7:0]  tx_data;
    logic        tx_we;
    logic        tx_busy;
    logic        mem_waitrequest;
    logic [1:0]  mem_id;
    logic [29:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_writedatamask;
    logic [31:0] mem_readdata;
    logic [1:0]  mem_readdataid;
    logic        busy;

    always #5 clock = ~clock;

    serial_mem_loader #(.MEM_ID(MID), .TIMEOUT_CYCLES(100)) dut (
        .clock             (clock),
        .rst               (rst),
        .rx_data           (rx_data),
        .rx_attention      (rx_attention),
        .tx_data           (tx_data),
        .tx_we             (tx_we),
        .tx_busy           (tx_busy),
        .mem_waitrequest   (mem_waitrequest),
        .mem_id            (mem_id),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_writedatamask (mem_writedatamask),
        .mem_readdata      (mem_readdata),
        .mem_readdataid    (mem_readdataid),
        .busy              (busy)
    );

    typedef struct packed {
        logic        wr;
        logic [29:0] addr;
        logic [31:0] data;
    } mem_op_t;

    mem_op_t     exp_mem[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] ref_mem[logic [29:0]];
    logic [31:0] psram[logic [29:0]];

    int checks = 0;
    int errors = 0;

    int      stall_cfg = 0;
    int      ret_delay_cfg = 0;
    bit      foreign_cfg = 0;
    int      req_cycles = 0;
    int      ret_cnt = 0;
    int      last_hold = 0;
    int      busy_left = 0;
    bit      acc_pend = 0;
    mem_op_t acc;
    logic [31:0] ret_data = 32'h0;

    function automatic logic [31:0] fill(logic [29:0] a);
        return {2'b00, a} ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // memory slave: stalls, accepts, returns tagged read data
    initial begin
        mem_waitrequest = 1'b1;
        mem_readdataid  = 2'd0;
        mem_readdata    = 32'h0;
        forever begin
            @(negedge clock);
            mem_waitrequest = 1'b1;
            mem_readdataid  = 2'd0;
            if (rst) begin
                req_cycles = 0;
                acc_pend   = 1'b0;
            end else if (acc_pend) begin
                mem_op_t e;
                acc_pend = 1'b0;
                chk("req_deassert", {30'h0, mem_read, mem_write}, 32'h0);
                checks++;
                if (exp_mem.size() == 0) begin
                    errors++;
                    $display("FAIL mem_unexpected: got wr=%0b addr=%h, required none",
                             acc.wr, acc.addr);
                end else begin
                    e = exp_mem.pop_front();
                    if (e.wr !== acc.wr || e.addr !== acc.addr ||
                        (e.wr && e.data !== acc.data)) begin
                        errors++;
                        $display("FAIL mem_op: got wr=%0b a=%h d=%h, required wr=%0b a=%h d=%h",
                                 acc.wr, acc.addr, acc.data, e.wr, e.addr, e.data);
                    end
                end
                if (acc.wr) begin
                    psram[acc.addr] = acc.data;
                end else begin
                    ret_data = psram.exists(acc.addr) ? psram[acc.addr] : fill(acc.addr);
                    ret_cnt  = ret_delay_cfg + 1;
                end
                req_cycles = 0;
            end else if (mem_read || mem_write) begin
                if (req_cycles >= stall_cfg) begin
                    mem_waitrequest = 1'b0;
                    acc_pend  = 1'b1;
                    acc.wr    = mem_write;
                    acc.addr  = mem_address;
                    acc.data  = mem_writedata;
                    last_hold = req_cycles + 1;
                    if (mem_write) chk("wmask", {28'h0, mem_writedatamask}, 32'hF);
                end else begin
                    req_cycles++;
                end
            end else if (req_cycles > 0) begin
                chk("req_dropped", {31'h0, mem_read}, 32'h1);
                req_cycles = 0;
            end
            if (ret_cnt > 0) begin
                ret_cnt--;
                if (ret_cnt == 0) begin
                    mem_readdataid = MID;
                    mem_readdata   = ret_data;
                end else if (foreign_cfg && ret_cnt == 1) begin
                    mem_readdataid = 2'd1;
                    mem_readdata   = 32'hFFFF_FFFF;
                end
            end
        end
    end

    // rs232out model and reply monitor
    initial begin
        logic [7:0] e;
        tx_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (tx_we) begin
                checks++;
                if (tx_busy) begin
                    errors++;
                    $display("FAIL tx_we_busy: got tx_we with tx_busy=1, required idle");
                end else if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: got %h, required no byte", tx_data);
                end else begin
                    e = exp_tx.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL tx_byte: got %h, required %h", tx_data, e);
                    end
                end
            end
            if (busy_left > 0) begin
                busy_left--;
                tx_busy = (busy_left > 0);
            end
            if (tx_we) begin
                busy_left = $urandom_range(1, 4);
                tx_busy   = 1'b1;
            end
        end
    end

    task automatic send_byte(logic [7:0] b, int gap);
        repeat (gap) @(negedge clock);
        @(negedge clock);
        rx_data      = b;
        rx_attention = 1'b1;
        @(negedge clock);
        rx_attention = 1'b0;
    endtask

    task automatic send_word(logic [31:0] w, int maxgap);
        for (int i = 3; i >= 0; i--)
            send_byte(w[8*i +: 8], $urandom_range(0, maxgap));
    endtask

    task automatic push_word(logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(w[8*i +: 8]);
    endtask

    task automatic do_write(logic [31:0] a, logic [31:0] d, int maxgap);
        mem_op_t op;
        op.wr = 1'b1; op.addr = a[31:2]; op.data = d;
        exp_mem.push_back(op);
        exp_tx.push_back(8'h4B);
        ref_mem[a[31:2]] = d;
        send_byte(8'h57, 0);
        send_word(a, maxgap);
        send_word(d, maxgap);
    endtask

    task automatic do_read(logic [31:0] a, int maxgap);
        mem_op_t op;
        logic [31:0] d;
        op.wr = 1'b0; op.addr = a[31:2]; op.data = 32'h0;
        exp_mem.push_back(op);
        d = ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : fill(a[31:2]);
        push_word(d);
        send_byte(8'h52, 0);
        send_word(a, maxgap);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy || exp_tx.size() != 0 || exp_mem.size() != 0) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL done_timeout: got busy=%0b tx_left=%0d mem_left=%0d, required idle",
                     busy, exp_tx.size(), exp_mem.size());
        end
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish within 1ms");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] a;
        logic [7:0]  b;
        int unsigned kind;

        rst = 1'b1;
        rx_data = 8'h00;
        rx_attention = 1'b0;
        #12;
        chk("rst_mem_read", {31'h0, mem_read}, 32'h0);
        chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
        chk("rst_tx_we", {31'h0, tx_we}, 32'h0);
        chk("rst_addr", {2'b0, mem_address}, 32'h0);
        chk("rst_wdata", mem_writedata, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("mem_id", {30'h0, mem_id}, 32'h3);
        chk("mask", {28'h0, mem_writedatamask}, 32'hF);
        @(negedge clock);
        rst = 1'b0;
        repeat (2) @(negedge clock);

        stall_cfg = 0; ret_delay_cfg = 0; foreign_cfg = 0;
        do_write(32'h0000_0100, 32'hDEAD_BEEF, 0);
        wait_done();
        do_write(32'h0000_0100, 32'h1234_5678, 0);
        wait_done();

        stall_cfg = 5; ret_delay_cfg = 3;
        do_read(32'h0000_0103, 0);
        send_byte(8'h41, 0);
        wait_done();
        chk("read_hold", last_hold, 6);

        stall_cfg = 0; foreign_cfg = 1;
        do_write(32'h0000_0100, 32'h0BAD_F00D, 0);
        wait_done();
        do_read(32'h0000_0100, 0);
        n = 0;
        while (!tx_busy && n < 200) begin
            @(posedge clock);
            n++;
        end
        chk("tx_busy_seen", {31'h0, tx_busy}, 32'h1);
        send_byte(8'h52, 0);
        wait_done();
        foreign_cfg = 0;

        exp_tx.push_back(8'h3F);
        send_byte(8'h41, 0);
        wait_done();

        for (int i = 0; i < 40; i++) begin
            stall_cfg     = $urandom_range(0, 3);
            ret_delay_cfg = $urandom_range(0, 4);
            foreign_cfg   = ($urandom_range(0, 1) == 1);
            a = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)) |
                (32'($urandom_range(0, 1)) << 31);
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                do_write(a, $urandom, 2);
            end else if (kind < 9) begin
                do_read(a, 2);
            end else begin
                b = 8'($urandom);
                if (b == CMD_READ || b == CMD_WRITE) b = 8'h00;
                exp_tx.push_back(RSP_ERR);
                send_byte(b, 0);
            end
            wait_done();
        end
        foreign_cfg = 0; stall_cfg = 0; ret_delay_cfg = 1;

`ifdef SERIAL_LOADER_TIMEOUT_EN
        send_byte(8'h57, 0);
        send_byte(8'h00, 0);
        repeat (101) @(negedge clock);
        chk("timeout_idle", {31'h0, busy}, 32'h0);
        do_read(32'h0000_0000, 0);
        wait_done();
`endif

        stall_cfg = 50;
        send_byte(8'h52, 0);
        send_word(32'h0000_0103, 0);
        n = 0;
        while (!mem_read && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("rst_req_seen", {31'h0, mem_read}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_mem_read", {31'h0, mem_read}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_addr", {2'b0, mem_address}, 32'h0);
        repeat (2) @(negedge clock);
        rst = 1'b0;
        stall_cfg = 0;
        ret_data = 32'hCAFE_BABE;
        ret_cnt = 3;
        repeat (20) @(negedge clock);
        chk("ghost_idle", {31'h0, busy}, 32'h0);

        do_write(32'h0000_001C, 32'hA5C3_0F96, 1);
        wait_done();
        do_read(32'h0000_001C, 1);
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
